// File: rtl/sprite_blit_writer_if.sv
// Bus bundle between the game controller / sprite ROM / SPRAM side and the blit writer.
//
// Handshake: the controller raises start for one cycle while busy=0 and done=0;
// the writer accepts it on that clock edge. It then holds busy high until the last
// write slot has completed and pulses done for exactly one cycle. Any start seen
// while busy or done is high is dropped, not queued. The ROM side has no
// back-pressure: rom_dout must be valid a fixed ROM_LATENCY cycles after rom_addr.
// The SPRAM write port takes fb_wr_en/fb_addr/fb_din unconditionally each cycle.
interface sprite_blit_writer_if #(
  parameter int FB_ADDR_WIDTH = 14
);
  logic                     start;
  logic                     mode;
  logic [5:0]               x_word;
  logic [8:0]               y;
  logic [15:0]              fill_word;
  logic                     busy;
  logic                     done;
  logic [7:0]               rom_addr;
  logic [15:0]              rom_dout;
  logic                     fb_wr_en;
  logic [FB_ADDR_WIDTH-1:0] fb_addr;
  logic [15:0]              fb_din;

  // Environment side: controller, sprite ROM and SPRAM together.
  modport master (
    output start, mode, x_word, y, fill_word, rom_dout,
    input  busy, done, rom_addr, fb_wr_en, fb_addr, fb_din
  );

  // Blit writer side.
  modport slave (
    input  start, mode, x_word, y, fill_word, rom_dout,
    output busy, done, rom_addr, fb_wr_en, fb_addr, fb_din
  );
endinterface

// File: rtl/sprite_blit_writer.sv
// Sprite blit writer: streams a 64x64 1bpp sprite (256 words) from the sprite ROM,
// or a constant fill word, into the SPRAM frame buffer at a word-aligned position,
// dropping the writes that fall outside the screen. The blit always takes the same
// number of cycles regardless of clipping.
module sprite_blit_writer #(
  parameter int FB_W_WORDS    = 40,
  parameter int FB_H          = 400,
  parameter int ROM_LATENCY   = 2,
  parameter int FB_ADDR_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_blit_writer_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] FB_W16  = 16'(FB_W_WORDS);
  localparam logic [15:0] FB_H16  = 16'(FB_H);
  localparam logic [7:0]  LAT8    = 8'(ROM_LATENCY);

  state_t state;
  state_t state_nxt;

  // Word counter: runs 0..255 in ISSUE (it is the ROM address), then is reused
  // in DRAIN to count the ROM_LATENCY+1 cycles until the last write lands.
  logic [7:0] k_cnt;

  // Parameters captured when a start is accepted.
  logic        mode_q;
  logic [5:0]  x_q;
  logic [8:0]  y_q;
  logic [15:0] fill_q;

  // Delay line carrying the issued word index alongside the ROM read latency.
  logic [ROM_LATENCY-1:0] pipe_vld;
  logic [7:0]             pipe_idx [ROM_LATENCY];

  // Write port registers.
  logic                     fb_wr_en_q;
  logic [FB_ADDR_WIDTH-1:0] fb_addr_q;
  logic [15:0]              fb_din_q;

  // Combinational outputs of the FSM.
  logic       busy_c;
  logic       done_c;
  logic [7:0] rom_addr_c;

  logic        accept;
  logic        slot_vld;
  logic [7:0]  slot_idx;
  logic [5:0]  slot_row;
  logic [1:0]  slot_col;
  logic [15:0] col_sum;
  logic [15:0] row_sum;
  logic        in_range;

  assign accept = (state == S_IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: ISSUE ends after word 255, DRAIN covers the ROM latency
  // plus the write register stage, DONE is a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start)          state_nxt = S_ISSUE;
      S_ISSUE: if (k_cnt == 8'd255)    state_nxt = S_DRAIN;
      S_DRAIN: if (k_cnt == LAT8)      state_nxt = S_DONE;
      S_DONE:                          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    busy_c     = 1'b0;
    done_c     = 1'b0;
    rom_addr_c = 8'd0;
    case (state)
      S_ISSUE: begin
        busy_c     = 1'b1;
        rom_addr_c = k_cnt;
      end
      S_DRAIN: busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  // Word counter: counts in ISSUE and DRAIN; the wrap from 255 to 0 on the
  // ISSUE->DRAIN transition starts the drain count at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k_cnt <= 8'd0;
    end else if ((state == S_ISSUE) || (state == S_DRAIN)) begin
      k_cnt <= (state_nxt == S_DONE) ? 8'd0 : k_cnt + 8'd1;
    end else begin
      k_cnt <= 8'd0;
    end
  end

  // Capture the request; later input changes do not disturb a running blit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      x_q    <= 6'd0;
      y_q    <= 9'd0;
      fill_q <= 16'd0;
    end else if (accept) begin
      mode_q <= bus.mode;
      x_q    <= bus.x_word;
      y_q    <= bus.y;
      fill_q <= bus.fill_word;
    end
  end

  // Index delay line: the word index issued with rom_addr arrives at the last
  // stage in the same cycle as its ROM data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_idx[i] <= 8'd0;
      end
    end else begin
      pipe_vld[0] <= (state == S_ISSUE);
      pipe_idx[0] <= k_cnt;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Destination position of the word in its write slot and the clip decision.
  // Sums are formed 16 bits wide so an off-screen position never wraps back
  // onto the screen.
  always_comb begin
    slot_vld = pipe_vld[ROM_LATENCY-1];
    slot_idx = pipe_idx[ROM_LATENCY-1];
    slot_row = slot_idx[7:2];
    slot_col = slot_idx[1:0];
    col_sum  = {10'd0, x_q} + {14'd0, slot_col};
    row_sum  = {7'd0, y_q} + {10'd0, slot_row};
    in_range = (col_sum < FB_W16) && (row_sum < FB_H16);
  end

  // SPRAM write register: address/data only move on an actual write so they
  // hold their last value between writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_wr_en_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_din_q   <= 16'd0;
    end else begin
      fb_wr_en_q <= slot_vld && in_range;
      if (slot_vld && in_range) begin
        fb_addr_q <= FB_ADDR_WIDTH'(row_sum * FB_W16 + col_sum);
        fb_din_q  <= mode_q ? fill_q : bus.rom_dout;
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.rom_addr = rom_addr_c;
  assign bus.fb_wr_en = fb_wr_en_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_din   = fb_din_q;
  assign state_dbg    = state;

endmodule
